// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: ram interface state encoding, data word and the
// error pattern returned on illegal ram accesses.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    localparam word_t RAM_ERR_WORD = 32'hBAD1_BAD1;

    // Even parity over a word, for callers that protect stored data.
    function automatic logic word_parity(input word_t w);
        return ^w;
    endfunction

endpackage

// File: rtl/ram_responder_ram_array.sv
// Word storage for the ram responder: one synchronous write port and an
// asynchronous read port. Contents are intentionally not reset.
module ram_responder_ram_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          CLK,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH_WORDS];

    // Synchronous write port.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_responder.sv
// RAM-side responder: decodes host ram requests, sequences a fixed-latency
// access, reports ramstate and returns ramload. A program port side-loads words.
module ram_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT         = 2,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic      CLK,
    input  logic      nRST,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    input  logic      ramREN,
    input  logic      ramWEN,
    output word_t     ramload,
    output ramstate_t ramstate,
    input  logic      prog_wen,
    input  word_t     prog_addr,
    input  word_t     prog_data
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(LAT + 1);
    localparam logic [CW-1:0] CNT_START = CW'(LAT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};

    logic          r_act;
    logic          r_op;
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_cnt;

    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_prog_idx;
    logic          w_oor;
    logic          w_prog_oor;
    logic          w_req;
    logic          w_err;
    logic          w_match;
    logic          w_cnt_zero;
    logic          w_host_we;
    logic          w_prog_we;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    word_t         w_wdata;
    word_t         w_rdata;
    ramstate_t     w_state;
    logic          w_unused;

    assign w_idx      = ramaddr[AW+1:2];
    assign w_prog_idx = prog_addr[AW+1:2];
    assign w_oor      = |ramaddr[31:AW+2];
    assign w_prog_oor = |prog_addr[31:AW+2];
    assign w_unused   = &{1'b0, ramaddr[1:0], prog_addr[1:0]};

    assign w_req      = ramREN ^ ramWEN;
    assign w_err      = (ramREN & ramWEN) | (w_req & w_oor);
    assign w_match    = r_act & (r_op == ramWEN) & (r_addr == w_idx) & ~w_oor;
    assign w_cnt_zero = (r_cnt == CNT_ZERO);

    // Host write commits only on the retiring ACCESS edge of a live write.
    assign w_host_we  = ~prog_wen & ~w_err & w_req & w_match & w_cnt_zero & r_op;
    assign w_prog_we  = prog_wen & ~w_prog_oor;

    // Write-port mux: program loader has priority over the host.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_addr;
        w_wdata = ramstore;
        if (w_prog_we) begin
            w_we    = 1'b1;
            w_waddr = w_prog_idx;
            w_wdata = prog_data;
        end else if (w_host_we) begin
            w_we    = 1'b1;
            w_waddr = r_addr;
            w_wdata = ramstore;
        end else begin
            w_we    = 1'b0;
        end
    end

    ram_responder_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram_array (
        .CLK     (CLK),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_addr),
        .o_rdata (w_rdata)
    );

    // Transaction sequencer: start, count down, retire or abort.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_act  <= 1'b0;
            r_op   <= 1'b0;
            r_addr <= {AW{1'b0}};
            r_cnt  <= CNT_ZERO;
        end else if (prog_wen || w_err || !w_req) begin
            r_act  <= 1'b0;
        end else if (!w_match) begin
            r_act  <= 1'b1;
            r_op   <= ramWEN;
            r_addr <= w_idx;
            r_cnt  <= CNT_START;
        end else if (!w_cnt_zero) begin
            r_cnt  <= r_cnt - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            r_act  <= 1'b0;
        end
    end

    // Ramstate decode in priority order; forced FREE while reset is held.
    always_comb begin
        w_state = BUSY;
        if (!nRST) begin
            w_state = FREE;
        end else if (w_err) begin
            w_state = ERROR;
        end else if (prog_wen && (ramREN || ramWEN)) begin
            w_state = BUSY;
        end else if (!w_req) begin
            w_state = FREE;
        end else if (w_match && w_cnt_zero) begin
            w_state = ACCESS;
        end else begin
            w_state = BUSY;
        end
    end

    // Read data is only driven for a read in ACCESS, or the error pattern.
    always_comb begin
        ramload = 32'h0000_0000;
        case (w_state)
            ACCESS:  ramload = r_op ? 32'h0000_0000 : w_rdata;
            ERROR:   ramload = RAM_ERR_WORD;
            default: ramload = 32'h0000_0000;
        endcase
    end

    assign ramstate = w_state;

endmodule
